// File: rtl/softmax_max_replay.sv
// softmax_max_replay: buffers one frame of N single-precision logits while
// tracking the running maximum, then replays every logit paired with the
// frame maximum over a valid/ready handshake.
module softmax_max_replay #(
  parameter int N = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  output logic        ready_in,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic [31:0] max_out,
  output logic        last_out,
  input  logic        ready_out,
  output logic        busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [31:0]   NEG_INF  = 32'hFF80_0000;

  typedef enum logic {LOAD, REPLAY} state_t;

  state_t        state;
  logic [31:0]   frame_buf [N];
  logic [IW-1:0] wcnt;
  logic [IW-1:0] ridx;
  logic [31:0]   max_reg;

  logic accept;
  logic xfer;

  // Raw-bit IEEE-754 "a > b"; +0 beats -0, equal patterns are not greater,
  // NaN and denormals get no special treatment.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31])
      return b[31];
    else if (!a[31])
      return a[30:0] > b[30:0];
    else
      return a[30:0] < b[30:0];
  endfunction

  assign accept = (state == LOAD) && valid_in;
  assign xfer   = (state == REPLAY) && ready_out;

  // Outputs decode only registered state, so no input reaches them combinationally.
  assign ready_in  = (state == LOAD);
  assign valid_out = (state == REPLAY);
  assign data_out  = (state == REPLAY) ? frame_buf[ridx] : 32'h0;
  assign max_out   = (state == REPLAY) ? max_reg : 32'h0;
  assign last_out  = (state == REPLAY) && (ridx == LAST_IDX);
  assign busy      = (wcnt != '0) || (state == REPLAY);

  // Logit storage: data only, never reset; stale contents are never replayed.
  always_ff @(posedge clk) begin
    if (accept)
      frame_buf[wcnt] <= data_in;
  end

  // Control FSM: load indices, running maximum and replay sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      wcnt    <= '0;
      ridx    <= '0;
      max_reg <= NEG_INF;
    end else begin
      case (state)
        LOAD: begin
          if (valid_in) begin
            // First element always loads, so the -inf seed is never compared.
            if (wcnt == '0 || fp_gt(data_in, max_reg))
              max_reg <= data_in;
            if (wcnt == LAST_IDX) begin
              wcnt  <= '0;
              ridx  <= '0;
              state <= REPLAY;
            end else begin
              wcnt <= wcnt + IW'(1);
            end
          end
        end
        REPLAY: begin
          if (xfer) begin
            if (ridx == LAST_IDX) begin
              ridx  <= '0;
              state <= LOAD;
            end else begin
              ridx <= ridx + IW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_max_replay.sv
// Directed bench for softmax_max_replay with N=4: hand-computed frames,
// backpressure, back-to-back frames and asynchronous reset mid-replay.
module tb_softmax_max_replay;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [31:0] max_out;
  logic        last_out;
  logic        ready_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] frame [N];
  logic [31:0] exp_max;

  softmax_max_replay #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .max_out   (max_out),
    .last_out  (last_out),
    .ready_out (ready_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive frame[] one logit per cycle; ends at the negedge after the final accept.
  task automatic load_frame();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("load_ready_in", 32'(ready_in), 32'd1);
      check("load_valid_out", 32'(valid_out), 32'd0);
      valid_in = 1'b1;
      data_in  = frame[i];
    end
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 32'h0;
    check("latency_valid_out", 32'(valid_out), 32'd1);
    check("latency_busy", 32'(busy), 32'd1);
  endtask

  // Replay elements first..N-1 with ready_out held high; ends after the last handshake.
  task automatic replay_from(input int first);
    for (int i = first; i < N; i++) begin
      check("rep_valid", 32'(valid_out), 32'd1);
      check("rep_data", data_out, frame[i]);
      check("rep_max", max_out, exp_max);
      check("rep_last", 32'(last_out), (i == N - 1) ? 32'd1 : 32'd0);
      check("rep_ready_in", 32'(ready_in), 32'd0);
      ready_out = 1'b1;
      @(negedge clk);
    end
    check("turn_valid_out", 32'(valid_out), 32'd0);
    check("turn_ready_in", 32'(ready_in), 32'd1);
    check("turn_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = 32'h0;
    ready_out = 1'b1;
    #12;
    check("rst_ready_in", 32'(ready_in), 32'd1);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_max_out", max_out, 32'h0);
    check("rst_last_out", 32'(last_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mixed signs, no backpressure.
    frame   = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000};
    exp_max = 32'h40000000;
    load_frame();
    replay_from(0);

    // All negative, with a 3-cycle stall at ridx=1 and ignored valid_in pulses.
    frame   = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hC0800000};
    exp_max = 32'hBF000000;
    ready_out = 1'b0;
    load_frame();
    check("bp_e0_data", data_out, frame[0]);
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_data", data_out, frame[1]);
      check("bp_hold_max", max_out, exp_max);
      check("bp_hold_last", 32'(last_out), 32'd0);
      check("bp_hold_ready_in", 32'(ready_in), 32'd0);
      valid_in = 1'b1;
      data_in  = 32'h7F000000;
      @(negedge clk);
    end
    valid_in = 1'b0;
    data_in  = 32'h0;
    replay_from(1);

    // Signed zeros and ties, then a second frame the cycle after the last handshake.
    frame   = '{32'h80000000, 32'h00000000, 32'h00000000, 32'hBF800000};
    exp_max = 32'h00000000;
    load_frame();
    replay_from(0);
    frame   = '{32'h40400000, 32'h3F800000, 32'hBF800000, 32'h00000000};
    exp_max = 32'h40400000;
    load_frame();
    replay_from(0);

    // Asynchronous reset at ridx=2, then a fresh frame from element 0.
    frame   = '{32'h42C80000, 32'hC2C80000, 32'h41000000, 32'h3F800000};
    exp_max = 32'h42C80000;
    load_frame();
    ready_out = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_data", data_out, frame[2]);
    rst = 1'b1;
    #1;
    check("mid_rst_valid_out", 32'(valid_out), 32'd0);
    check("mid_rst_data_out", data_out, 32'h0);
    check("mid_rst_max_out", max_out, 32'h0);
    check("mid_rst_last_out", 32'(last_out), 32'd0);
    check("mid_rst_ready_in", 32'(ready_in), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame   = '{32'h3F800000, 32'h41200000, 32'hC1200000, 32'h40A00000};
    exp_max = 32'h41200000;
    load_frame();
    replay_from(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
